// File: rtl/aes_key_sched_ctrl.sv
// Key-load sequencer and round-key read-port arbiter between keymem, the key
// expander and the encrypt/decrypt engines.
module aes_key_sched_ctrl #(
  parameter int EXP_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        key_load,
  input  logic [1:0]  key_len,
  input  logic        enc_busy,
  input  logic        dec_busy,
  input  logic [14:0] valid_bits,
  output logic        kexp_clear,
  output logic        kexp_start,
  output logic [1:0]  key_len_q,
  output logic [3:0]  nr,
  output logic        key_exp_status,
  output logic        key_err,
  input  logic        enc_req,
  input  logic [3:0]  enc_addr,
  input  logic        dec_req,
  input  logic [3:0]  dec_addr,
  output logic        enc_gnt,
  output logic        dec_gnt,
  output logic        enc_rvalid,
  output logic        dec_rvalid,
  output logic [3:0]  mem_raddr,
  output logic        mem_ren
);

  localparam int NUM_REQ = 2;
  localparam int CW      = $clog2(EXP_TIMEOUT) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_DRAIN, S_CLEAR, S_START, S_EXPAND, S_READY
  } state_t;

  state_t                          state, state_nxt;
  logic [CW-1:0]                   cnt;
  logic                            err_q, err_nxt;
  logic                            last_dec;
  logic [NUM_REQ-1:0]              rv_q;
  logic [NUM_REQ-1:0]              req_v, elig, gnt;
  logic [NUM_REQ-1:0][3:0]         addr_v;
  logic [3:0]                      nk;
  logic [15:0]                     mask_w, vb16;
  logic                            covered, load_ok, load_bad, timeout;

  assign load_ok  = key_load && (key_len != 2'b11);
  assign load_bad = key_load && (key_len == 2'b11);

  assign nr      = 4'd10 + {1'b0, key_len_q, 1'b0};
  assign nk      = nr + 4'd1;
  assign mask_w  = (16'd1 << nk) - 16'd1;
  assign vb16    = {1'b0, valid_bits};
  assign covered = &(valid_bits | ~mask_w[14:0]);
  assign timeout = (cnt == CW'(EXP_TIMEOUT - 1));

  // Requester 0 is encrypt, 1 is decrypt.
  assign req_v  = {dec_req, enc_req};
  assign addr_v = {dec_addr, enc_addr};

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_elig
    assign elig[i] = req_v[i] && (addr_v[i] < nk) && vb16[addr_v[i]];
  end

  // Encrypt wins a tie only when decrypt had the last grant.
  assign gnt[0] = (state == S_READY) && elig[0] && (!elig[1] || last_dec);
  assign gnt[1] = (state == S_READY) && elig[1] && !gnt[0];

  assign enc_gnt    = gnt[0];
  assign dec_gnt    = gnt[1];
  assign mem_ren    = |gnt;
  assign mem_raddr  = gnt[0] ? enc_addr : (gnt[1] ? dec_addr : 4'd0);
  assign enc_rvalid = rv_q[0];
  assign dec_rvalid = rv_q[1];

  assign kexp_clear     = (state == S_CLEAR);
  assign kexp_start     = (state == S_START);
  assign key_exp_status = (state == S_READY);
  assign key_err        = err_q;

  always_comb begin
    state_nxt = state;
    err_nxt   = load_bad;
    case (state)
      S_IDLE:   state_nxt = S_IDLE;
      S_DRAIN:  if (!enc_busy && !dec_busy && !(|rv_q)) state_nxt = S_CLEAR;
      S_CLEAR:  state_nxt = S_START;
      S_START:  state_nxt = S_EXPAND;
      S_EXPAND: begin
        if (covered) begin
          state_nxt = S_READY;
        end else if (timeout) begin
          state_nxt = S_IDLE;
          err_nxt   = 1'b1;
        end
      end
      S_READY:  state_nxt = S_READY;
      default:  state_nxt = S_IDLE;
    endcase
    // A new legal key restarts the sequence from any state.
    if (load_ok) begin
      state_nxt = S_DRAIN;
      err_nxt   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      err_q     <= 1'b0;
      last_dec  <= 1'b1;
      rv_q      <= '0;
      key_len_q <= 2'b00;
    end else begin
      state <= state_nxt;
      err_q <= err_nxt;
      rv_q  <= gnt;
      if (load_ok) key_len_q <= key_len;
      if (|gnt)    last_dec  <= gnt[1];
      if (state == S_START)       cnt <= '0;
      else if (state == S_EXPAND) cnt <= cnt + 1'b1;
    end
  end

endmodule
